// File: rtl/npu_pkg.sv
// Shared NPU queue constants: default word width, queue depth and error-flag bit positions.
package npu_pkg;
  localparam int NPU_DATA_W      = 32;
  localparam int NPU_QUEUE_DEPTH = 8;

  localparam int ERR_CPU_OVF = 0;
  localparam int ERR_CPU_UDF = 1;
  localparam int ERR_RES_OVF = 2;
endpackage

// File: rtl/npu_io_queue_if.sv
// CPU/NPU-facing signal bundle of npu_io_queue; slave = queue endpoint, master = CPU stage + NPU core.
// oErr exists only when NPU_QUEUE_ERR_EN is defined.
interface npu_io_queue_if #(parameter int DATA_W = 32);
  logic              iCfgOp, iCfgWe;
  logic [DATA_W-1:0] iCfgData;
  logic              iInOp, iInWe;
  logic [DATA_W-1:0] iInData;
  logic              iOutOp, iOutRe;
  logic [DATA_W-1:0] oOutData;
  logic              oStall;
  logic [DATA_W-1:0] oCfgWord;
  logic              oCfgValid, iCfgReady;
  logic [DATA_W-1:0] oInWord;
  logic              oInValid, iInReady;
  logic [DATA_W-1:0] iResWord;
  logic              iResValid, oResReady;
`ifdef NPU_QUEUE_ERR_EN
  logic [2:0]        oErr;

  modport slave (
    input  iCfgOp, iCfgWe, iCfgData, iInOp, iInWe, iInData, iOutOp, iOutRe,
           iCfgReady, iInReady, iResWord, iResValid,
    output oOutData, oStall, oCfgWord, oCfgValid, oInWord, oInValid, oResReady, oErr
  );
  modport master (
    output iCfgOp, iCfgWe, iCfgData, iInOp, iInWe, iInData, iOutOp, iOutRe,
           iCfgReady, iInReady, iResWord, iResValid,
    input  oOutData, oStall, oCfgWord, oCfgValid, oInWord, oInValid, oResReady, oErr
  );
`else
  modport slave (
    input  iCfgOp, iCfgWe, iCfgData, iInOp, iInWe, iInData, iOutOp, iOutRe,
           iCfgReady, iInReady, iResWord, iResValid,
    output oOutData, oStall, oCfgWord, oCfgValid, oInWord, oInValid, oResReady
  );
  modport master (
    output iCfgOp, iCfgWe, iCfgData, iInOp, iInWe, iInData, iOutOp, iOutRe,
           iCfgReady, iInReady, iResWord, iResValid,
    input  oOutData, oStall, oCfgWord, oCfgValid, oInWord, oInValid, oResReady
  );
`endif
endinterface

// File: rtl/npu_sync_fifo.sv
// Circular FWFT FIFO: pushed word visible at head one edge later, pop reads head combinationally.
// Push while full and pop while empty are ignored; both checked against pre-edge state.
module npu_sync_fifo import npu_pkg::*; #(
  parameter int DEPTH  = NPU_QUEUE_DEPTH,
  parameter int DATA_W = NPU_DATA_W
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iPush,
  input  logic [DATA_W-1:0]      iPushData,
  input  logic                   iPop,
  output logic [DATA_W-1:0]      oHead,
  output logic                   oFull,
  output logic                   oEmpty,
  output logic [$clog2(DEPTH):0] oCount
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic              pushOk, popOk;

  assign oFull  = (oCount == (AW+1)'(DEPTH));
  assign oEmpty = (oCount == '0);
  assign pushOk = iPush && !oFull;
  assign popOk  = iPop && !oEmpty;
  assign oHead  = mem[rdPtr];

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   oCount <= oCount + 1'b1;
        2'b01:   oCount <= oCount - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge iClk) begin
    if (pushOk) mem[wrPtr] <= iPushData;
  end
endmodule

// File: rtl/npu_io_queue.sv
// NPU endpoint of the CPU<->NPU queues: CFG/IN to the NPU, RES back to the CPU (FWFT, 1-cycle push-to-visible).
// CPU stalls on push-to-full or pop-from-empty; NPU sees valid/ready. Sticky oErr flags with NPU_QUEUE_ERR_EN.
module npu_io_queue import npu_pkg::*; #(
  parameter int DEPTH  = NPU_QUEUE_DEPTH,
  parameter int DATA_W = NPU_DATA_W
) (
  input logic          iClk,
  input logic          iRst_n,
  npu_io_queue_if.slave io
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              cfgFull, cfgEmpty, inFull, inEmpty, resFull, resEmpty;
  logic [CW-1:0]     cfgCount, inCount, resCount;
  logic [DATA_W-1:0] resHead;
  logic              cfgPop, inPop, resPush;

  assign cfgPop  = !cfgEmpty && io.iCfgReady;
  assign inPop   = !inEmpty && io.iInReady;
  assign resPush = io.iResValid && !resFull;

  npu_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) uCfgQ (
    .iClk(iClk), .iRst_n(iRst_n),
    .iPush(io.iCfgWe), .iPushData(io.iCfgData), .iPop(cfgPop),
    .oHead(io.oCfgWord), .oFull(cfgFull), .oEmpty(cfgEmpty), .oCount(cfgCount)
  );

  npu_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) uInQ (
    .iClk(iClk), .iRst_n(iRst_n),
    .iPush(io.iInWe), .iPushData(io.iInData), .iPop(inPop),
    .oHead(io.oInWord), .oFull(inFull), .oEmpty(inEmpty), .oCount(inCount)
  );

  npu_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) uResQ (
    .iClk(iClk), .iRst_n(iRst_n),
    .iPush(resPush), .iPushData(io.iResWord), .iPop(io.iOutRe),
    .oHead(resHead), .oFull(resFull), .oEmpty(resEmpty), .oCount(resCount)
  );

  assign io.oCfgValid = !cfgEmpty;
  assign io.oInValid  = !inEmpty;
  assign io.oResReady = !resFull;
  assign io.oOutData  = resEmpty ? '0 : resHead;
  assign io.oStall    = (io.iCfgOp && cfgFull) || (io.iInOp && inFull) || (io.iOutOp && resEmpty);

  // Occupancy must never exceed DEPTH and must agree with the full flag.
  assert property (@(posedge iClk) disable iff (!iRst_n)
    (cfgCount <= CW'(DEPTH)) && (inCount <= CW'(DEPTH)) && (resCount <= CW'(DEPTH)) &&
    (cfgFull == (cfgCount == CW'(DEPTH))) && (inFull == (inCount == CW'(DEPTH))) &&
    (resFull == (resCount == CW'(DEPTH))));

`ifdef NPU_QUEUE_ERR_EN
  logic [2:0] errQ;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      errQ <= '0;
    end else begin
      if ((io.iCfgWe && cfgFull) || (io.iInWe && inFull)) errQ[ERR_CPU_OVF] <= 1'b1;
      if (io.iOutRe && resEmpty)                         errQ[ERR_CPU_UDF] <= 1'b1;
      if (io.iResValid && resFull)                       errQ[ERR_RES_OVF] <= 1'b1;
    end
  end

  assign io.oErr = errQ;
`endif
endmodule

// File: tb/tb_npu_io_queue.sv
// Bench for npu_io_queue: queue-based reference model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_npu_io_queue;
  import npu_pkg::*;

  localparam int DEPTH = NPU_QUEUE_DEPTH;
  localparam int DW    = NPU_DATA_W;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  npu_io_queue_if #(.DATA_W(DW)) bus ();

  npu_io_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .io(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    bus.iCfgOp = 0; bus.iCfgWe = 0; bus.iCfgData = '0;
    bus.iInOp = 0;  bus.iInWe = 0;  bus.iInData = '0;
    bus.iOutOp = 0; bus.iOutRe = 0;
    bus.iCfgReady = 0; bus.iInReady = 0;
    bus.iResWord = '0; bus.iResValid = 0;
  endtask

  // Reference model: three plain queues plus sticky error bits.
  logic [DW-1:0] mCfg[$], mIn[$], mRes[$];
  logic [2:0]    mErr;
  bit            armed = 0;

  always @(posedge iClk) begin
    bit cPush, cPop, iPush, iPop, rPush, rPop;
    if (!iRst_n) begin
      mCfg.delete(); mIn.delete(); mRes.delete();
      mErr = '0;
      armed = 1;
    end else begin
      cPop  = (mCfg.size() != 0) && bus.iCfgReady;
      cPush = bus.iCfgWe && (mCfg.size() < DEPTH);
      iPop  = (mIn.size() != 0) && bus.iInReady;
      iPush = bus.iInWe && (mIn.size() < DEPTH);
      rPop  = bus.iOutRe && (mRes.size() != 0);
      rPush = bus.iResValid && (mRes.size() < DEPTH);
      if ((bus.iCfgWe && mCfg.size() == DEPTH) || (bus.iInWe && mIn.size() == DEPTH)) mErr[0] = 1'b1;
      if (bus.iOutRe && mRes.size() == 0)      mErr[1] = 1'b1;
      if (bus.iResValid && mRes.size() == DEPTH) mErr[2] = 1'b1;
      if (cPop)  void'(mCfg.pop_front());
      if (cPush) mCfg.push_back(bus.iCfgData);
      if (iPop)  void'(mIn.pop_front());
      if (iPush) mIn.push_back(bus.iInData);
      if (rPop)  void'(mRes.pop_front());
      if (rPush) mRes.push_back(bus.iResWord);
    end
  end

  always @(negedge iClk) begin
    logic stallExp;
    #2;
    if (armed) begin
      stallExp = (bus.iCfgOp && mCfg.size() == DEPTH) || (bus.iInOp && mIn.size() == DEPTH) ||
                 (bus.iOutOp && mRes.size() == 0);
      check("cfg_valid", 32'(bus.oCfgValid), 32'(mCfg.size() != 0));
      if (mCfg.size() != 0) check("cfg_word", bus.oCfgWord, mCfg[0]);
      check("in_valid", 32'(bus.oInValid), 32'(mIn.size() != 0));
      if (mIn.size() != 0) check("in_word", bus.oInWord, mIn[0]);
      check("res_ready", 32'(bus.oResReady), 32'(mRes.size() < DEPTH));
      check("out_data", bus.oOutData, (mRes.size() != 0) ? mRes[0] : 32'h0);
      check("stall", 32'(bus.oStall), 32'(stallExp));
`ifdef NPU_QUEUE_ERR_EN
      check("err", 32'(bus.oErr), 32'(mErr));
`endif
    end
  end

  initial begin
    int cnt;
    clr();
    iRst_n = 0;
    repeat (2) @(negedge iClk);
    iRst_n = 1;
    #3;
    check("rst_cfg_valid", 32'(bus.oCfgValid), 0);
    check("rst_in_valid", 32'(bus.oInValid), 0);
    check("rst_res_ready", 32'(bus.oResReady), 1);
    check("rst_out_data", bus.oOutData, 0);
    check("rst_stall", 32'(bus.oStall), 0);

    // CFG: three pushes held back, then streamed out in order.
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      bus.iCfgOp = 1; bus.iCfgWe = 1; bus.iCfgData = 32'hA1 + i;
      if (i > 0) begin
        #3;
        check("t1_cfg_valid", 32'(bus.oCfgValid), 1);
        check("t1_cfg_head", bus.oCfgWord, 32'hA1);
      end
    end
    @(negedge iClk); clr(); bus.iCfgReady = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge iClk);
      #3;
      check("t1_drain_word", bus.oCfgWord, 32'hA1 + i);
    end
    @(negedge iClk); #3;
    check("t1_drained", 32'(bus.oCfgValid), 0);

    // IN: fill, stall on full, one NPU pop frees a slot for 0x55.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge iClk); clr();
      bus.iInOp = 1; bus.iInWe = 1; bus.iInData = 32'h10 + i;
    end
    @(negedge iClk); clr(); bus.iInOp = 1; #3;
    check("t2_stall_full", 32'(bus.oStall), 1);
    @(negedge iClk); bus.iInReady = 1; #3;
    check("t2_stall_pop_cycle", 32'(bus.oStall), 1);
    @(negedge iClk); bus.iInReady = 0; #3;
    check("t2_stall_released", 32'(bus.oStall), 0);
    bus.iInWe = 1; bus.iInData = 32'h55;
    @(negedge iClk); clr(); bus.iInOp = 1; #3;
    check("t2_stall_refull", 32'(bus.oStall), 1);
    @(negedge iClk); clr(); bus.iInReady = 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge iClk);
      #3;
      check("t2_order", bus.oInWord, (i < DEPTH - 1) ? 32'h11 + i : 32'h55);
    end
    @(negedge iClk); #3;
    check("t2_drained", 32'(bus.oInValid), 0);

    // RES: pop-from-empty stall until the NPU delivers a word.
    @(negedge iClk); clr(); bus.iOutOp = 1; #3;
    check("t3_stall_empty", 32'(bus.oStall), 1);
    check("t3_out_zero", bus.oOutData, 0);
    @(negedge iClk); bus.iResValid = 1; bus.iResWord = 32'h1234;
    @(negedge iClk); bus.iResValid = 0; #3;
    check("t3_stall_released", 32'(bus.oStall), 0);
    check("t3_out_word", bus.oOutData, 32'h1234);
    bus.iOutRe = 1;
    @(negedge iClk); bus.iOutRe = 0; #3;
    check("t3_empty_again", 32'(bus.oStall), 1);
    check("t3_out_zero_again", bus.oOutData, 0);

    // RES full with simultaneous NPU push and CPU pop: only the pop lands.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge iClk); clr();
      bus.iResValid = 1; bus.iResWord = 32'h200 + i;
    end
    @(negedge iClk); clr(); #3;
    check("t4_not_ready", 32'(bus.oResReady), 0);
    check("t4_head", bus.oOutData, 32'h200);
    bus.iResValid = 1; bus.iResWord = 32'h999; bus.iOutOp = 1; bus.iOutRe = 1;
    @(negedge iClk); clr(); bus.iOutOp = 1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (bus.oStall) begin
        bus.iOutRe = 0;
        break;
      end
      check("t4_word", bus.oOutData, 32'h201 + cnt);
      bus.iOutRe = 1;
      cnt++;
      @(negedge iClk);
    end
    check("t4_count", cnt, DEPTH - 1);

    // CFG wrap-around: 3 words resident, 20 simultaneous push/pop pairs.
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk); clr();
      bus.iCfgWe = 1; bus.iCfgData = 32'hC00 + i;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge iClk); clr();
      bus.iCfgWe = 1; bus.iCfgReady = 1; bus.iCfgData = 32'hC03 + i; #3;
      check("t5_wrap_head", bus.oCfgWord, 32'hC00 + i);
    end
    @(negedge iClk); clr(); bus.iCfgReady = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge iClk);
      #3;
      check("t5_tail", bus.oCfgWord, 32'hC14 + i);
    end
    @(negedge iClk); #3;
    check("t5_drained", 32'(bus.oCfgValid), 0);

    // Clean reset, then overflow flag, then reset mid-stream.
    @(negedge iClk); clr(); iRst_n = 0;
    @(negedge iClk); iRst_n = 1;
`ifdef NPU_QUEUE_ERR_EN
    #3; check("t6_err_clear", 32'(bus.oErr), 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge iClk); clr();
      bus.iCfgOp = 1; bus.iCfgWe = 1; bus.iCfgData = 32'hE0 + i;
    end
    @(negedge iClk); clr();
    bus.iCfgOp = 1; bus.iCfgWe = 1; bus.iCfgData = 32'hEE;
    bus.iInWe = 1; bus.iInData = 32'h77; bus.iResValid = 1; bus.iResWord = 32'h88;
    @(negedge iClk); clr(); #3;
    check("t6_in_valid", 32'(bus.oInValid), 1);
    check("t6_out_word", bus.oOutData, 32'h88);
`ifdef NPU_QUEUE_ERR_EN
    check("t6_err_ovf", 32'(bus.oErr[ERR_CPU_OVF]), 1);
    repeat (3) @(negedge iClk);
    #3; check("t6_err_sticky", 32'(bus.oErr), 32'h1);
`endif
    @(negedge iClk); iRst_n = 0; bus.iInWe = 1; bus.iInData = 32'h99;
    @(negedge iClk); clr(); iRst_n = 1; #3;
    check("t6_rst_cfg_valid", 32'(bus.oCfgValid), 0);
    check("t6_rst_in_valid", 32'(bus.oInValid), 0);
    check("t6_rst_res_ready", 32'(bus.oResReady), 1);
    check("t6_rst_out", bus.oOutData, 0);
`ifdef NPU_QUEUE_ERR_EN
    check("t6_rst_err", 32'(bus.oErr), 0);
`endif

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge iClk);
      iRst_n         = ($urandom_range(0, 499) != 0);
      bus.iCfgOp     = 1'($urandom_range(0, 1));
      bus.iCfgWe     = 1'($urandom_range(0, 1));
      bus.iCfgData   = $urandom;
      bus.iInOp      = 1'($urandom_range(0, 1));
      bus.iInWe      = 1'($urandom_range(0, 1));
      bus.iInData    = $urandom;
      bus.iOutOp     = 1'($urandom_range(0, 1));
      bus.iOutRe     = 1'($urandom_range(0, 1));
      bus.iCfgReady  = ($urandom_range(0, 2) == 0);
      bus.iInReady   = ($urandom_range(0, 2) == 0);
      bus.iResValid  = 1'($urandom_range(0, 1));
      bus.iResWord   = $urandom;
    end
    @(negedge iClk); clr(); iRst_n = 1;
    repeat (2) @(negedge iClk);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/npu_io_queue.md
# npu_io_queue

NPU-side endpoint of the CPU↔NPU FIFO interface driven by the execution stage.
- Buffers configuration words and input data words pushed by the CPU, and presents them to the NPU core over valid/ready.
- Buffers NPU result words and serves them to CPU dequeue operations combinationally (first-word-fall-through).
- Generates the CPU pipeline stall whenever a requested push targets a full queue or a requested pop targets an empty queue.

## Interface
Parameters:
- DEPTH, 8, entries per queue; power of two, ≥2
- DATA_W, 32, word width

Ports:
- iClk  in  1  clock
- iRst_n  in  1  reset; synchronous, active-low
- iCfgOp  in  1  config push requested this cycle (ungated)
- iCfgWe  in  1  config push commit (CPU gates with !stall)
- iCfgData  in  DATA_W  config word
- iInOp  in  1  data push requested (ungated)
- iInWe  in  1  data push commit
- iInData  in  DATA_W  input data word
- iOutOp  in  1  result pop requested (ungated)
- iOutRe  in  1  result pop commit
- oOutData  out  DATA_W  head of result queue; 0 when empty
- oStall  out  1  CPU stall request
- oCfgWord / oCfgValid / iCfgReady  out/out/in  DATA_W/1/1  config stream to NPU
- oInWord / oInValid / iInReady  out/out/in  DATA_W/1/1  data stream to NPU
- iResWord / iResValid / oResReady  in/in/out  DATA_W/1/1  result stream from NPU
- oErr  out  3  sticky errors {res_overflow, cpu_underflow, cpu_overflow}; present only with NPU_QUEUE_ERR_EN

## Operation
- Three independent circular queues: CFG (CPU→NPU), IN (CPU→NPU), RES (NPU→CPU).
- Each queue: write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits). full = count==DEPTH; empty = count==0.
- Push accepted iff we && !full. Pop accepted iff re && !empty. A push and a pop in the same cycle are both evaluated against the pre-cycle state; count is unchanged when both are accepted.
- A push to a full queue is accepted neither when the same cycle carries a pop. A push while full is dropped; a pop while empty is ignored.
- Pointer and count updates:
  - CFG: pushed by iCfgWe, popped by oCfgValid&&iCfgReady.
  - IN: pushed by iInWe, popped by oInValid&&iInReady.
  - RES: pushed by iResValid&&oResReady, popped by iOutRe.
- oCfgValid = !cfg_empty, oInValid = !in_empty, oResReady = !res_full.
- oCfgWord / oInWord = head entry.
- oOutData = head entry when !res_empty, else 0.
- oStall = (iCfgOp&&cfg_full) | (iInOp&&in_full) | (iOutOp&&res_empty). Purely combinational; no state.

## Timing
- Reset (iRst_n=0 at posedge): all pointers and counts = 0, so oCfgValid=0, oInValid=0, oResReady=1, oOutData=0, oErr=0. oStall follows its inputs (0 when ops are low). Storage arrays are not reset.
- Reset mid-operation: all queued words are discarded in that cycle.
- Push-to-visible latency: 1 cycle. A word written at edge N is on oCfgWord/oInWord/oOutData with valid asserted after edge N.
- Pop: combinational read of the head entry; the pointer advances at the edge.
- Full-to-not-full: oStall for a push deasserts in the cycle after the consumer's pop edge.
- Empty-to-non-empty: oStall for a pop deasserts in the cycle after the NPU push edge.

## Configuration
- NPU_QUEUE_ERR_EN defined:
  - oErr exists.
  - bit0 sets on iCfgWe||iInWe to a full queue.
  - bit1 sets on iOutRe while RES is empty.
  - bit2 sets on iResValid while RES is full.
  - Bits are sticky and clear only on reset.
- NPU_QUEUE_ERR_EN undefined: no oErr port and no flag logic. Illegal operations are silently dropped as described above.

## Structure
- Shared package npu_pkg holds:
  - NPU_DATA_W = 32
  - NPU_QUEUE_DEPTH = 8
  - error-bit index constants ERR_CPU_OVF = 0, ERR_CPU_UDF = 1, ERR_RES_OVF = 2
- Sub-module npu_sync_fifo: parameterised FWFT FIFO with push, pop, head, full, empty, and count outputs. It is instantiated three times.
- The top level contains only the handshake mapping, stall logic, and error flags.

## Test plan
- Reset, then 3 CFG pushes 0xA1, 0xA2, 0xA3 with iCfgReady=0 → oCfgValid=1 from the next cycle, oCfgWord=0xA1. Raise iCfgReady → words emerge 0xA1, 0xA2, 0xA3 on consecutive cycles, then oCfgValid=0.
- Fill IN with 8 words, then hold iInOp=1 → oStall=1. Pulse iInReady for one cycle → oStall=0 the following cycle. A push of 0x55 lands and becomes the 8th entry; order is preserved.
- iOutOp=1 with RES empty → oStall=1, oOutData=0. NPU pushes 0x1234 → next cycle oStall=0, oOutData=0x1234. iOutRe pops it → RES empty.
- RES full and simultaneous iResValid=1 with iOutRe=1 → pop accepted, NPU push refused (oResReady=0), count drops to 7.
- Pointer wrap-around: 20 push/pop pairs through CFG with DEPTH=8 → data is intact and counts stay consistent across wrap.
- With NPU_QUEUE_ERR_EN: iCfgWe to full CFG → oErr[0]=1 and stays set. Then reset mid-stream → oErr=0, all valids drop, oResReady=1.
